// File: rtl/aes_pkg.sv
// Shared AES constants and types: Rcon table, key-schedule FSM states, round count.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  // Rcon[1..10], index 1 in the MSB byte
  localparam logic [79:0] RCON_TABLE = 80'h01020408102040801B36;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    SERVE
  } state_t;

  // Rounds outside 1..10 return 0 so an unused g() evaluation adds no constant
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 1; i <= NUM_ROUNDS; i++) begin
      if (round == 4'(i)) v = RCON_TABLE[8*(NUM_ROUNDS-i) +: 8];
    end
    return v;
  endfunction

endpackage

// File: rtl/aes_key_g.sv
// Key-schedule g(): RotWord, SubWord, then Rcon[round] into the MSB byte.
module aes_key_g
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [3:0]  i_round,
  output logic [31:0] o_word
);

  logic [31:0] w_rot;
  logic [31:0] w_sub;

  assign w_rot = {i_word[23:0], i_word[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (w_rot[8*i +: 8]),
      .o_byte (w_sub[8*i +: 8])
    );
  end

  assign o_word = w_sub ^ {rcon(i_round), 24'h000000};

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box, combinational table lookup.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Entry 0 sits in the top byte, so the lookup offset is 8*(255-i_byte)
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_byte = SBOX[{~i_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 decryption-order key schedule: expands forward to round 10 in place,
// then walks back to round 0 one handshake at a time using one 128-bit register.
module aes_inv_key_sched
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic         flush,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [3:0]   r_cnt;
  logic [3:0]   w_cnt_nxt;
  logic [127:0] r_key;
  logic [127:0] w_key_nxt;

  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_f0, w_f1, w_f2, w_f3;
  logic [31:0]  w_inv3;
  logic [31:0]  w_g_in;
  logic [31:0]  w_g_out;
  logic [3:0]   w_g_round;
  logic [127:0] w_fwd;
  logic [127:0] w_inv;
  logic         w_serve;

  assign {w_w0, w_w1, w_w2, w_w3} = r_key;

  // Going backwards, the register holds round r words w4..w7; w3' = w7 ^ w6
  assign w_inv3    = w_w3 ^ w_w2;
  assign w_g_in    = (r_state == EXPAND) ? w_w3 : w_inv3;
  assign w_g_round = (r_state == EXPAND) ? (r_cnt + 4'd1) : r_cnt;

  aes_key_g u_key_g (
    .i_word  (w_g_in),
    .i_round (w_g_round),
    .o_word  (w_g_out)
  );

  assign w_f0  = w_w0 ^ w_g_out;
  assign w_f1  = w_f0 ^ w_w1;
  assign w_f2  = w_f1 ^ w_w2;
  assign w_f3  = w_f2 ^ w_w3;
  assign w_fwd = {w_f0, w_f1, w_f2, w_f3};
  assign w_inv = {w_w0 ^ w_g_out, w_w1 ^ w_w0, w_w2 ^ w_w1, w_inv3};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_key   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_key   <= w_key_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_key_nxt   = r_key;
    if (flush) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (key_valid) begin
            w_key_nxt   = key_in;
            w_cnt_nxt   = 4'd0;
            w_state_nxt = EXPAND;
          end
        end
        EXPAND: begin
          w_key_nxt = w_fwd;
          w_cnt_nxt = r_cnt + 4'd1;
          if (r_cnt == 4'(NUM_ROUNDS - 1)) w_state_nxt = SERVE;
        end
        SERVE: begin
          if (rk_ready) begin
            if (r_cnt != 4'd0) begin
              w_key_nxt = w_inv;
              w_cnt_nxt = r_cnt - 4'd1;
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  assign w_serve   = (r_state == SERVE);
  assign key_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign rk_valid  = w_serve;
  assign rk_out    = w_serve ? r_key : '0;
  assign rk_round  = w_serve ? r_cnt : 4'd0;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: randomized keys and stalls against a FIPS-197
// key-expansion model built from GF(2^8) arithmetic.
module tb_aes_inv_key_sched;

  logic         clk;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         flush;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;

  int tests_run, tests_failed;
  int lat, obs_n, bad_seq, bad_stall, bad_ready;
  logic [127:0] obs     [11];
  logic [127:0] exp_rk  [11];
  logic [7:0]   sb_m    [256];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_inv_key_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .flush     (flush),
    .rk_out    (rk_out),
    .rk_round  (rk_round),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not reach the summary line");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox_model();
    logic [7:0] inv, x;
    for (int i = 0; i < 256; i++) begin
      x = 8'(i);
      inv = 8'h00;
      if (i != 0)
        for (int j = 1; j < 256; j++) if (gmul(x, 8'(j)) == 8'h01) inv = 8'(j);
      sb_m[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    {w[0], w[1], w[2], w[3]} = key;
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_m[t[31:24]], sb_m[t[23:16]], sb_m[t[15:8]], sb_m[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Loads a key and drains the full sequence; must be entered just after a negedge.
  task automatic run_seq(input logic [127:0] key, input bit rand_ready, input bit poke_kv);
    logic [127:0] prev_out;
    logic [3:0]   prev_rnd;
    bit           stalled;
    int           guard;
    model_expand(key);
    obs_n = 0; bad_seq = 0; bad_stall = 0; bad_ready = 0; lat = 0;
    key_in = key; key_valid = 1'b1; rk_ready = 1'b0;
    @(posedge clk); lat = 1;
    @(negedge clk);
    key_valid = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    while (rk_valid !== 1'b1 && lat < 40) begin
      if (key_ready !== 1'b0 || busy !== 1'b1) bad_ready++;
      if (poke_kv) key_valid = 1'($urandom_range(0, 1));
      @(posedge clk); lat++;
      @(negedge clk);
    end
    stalled = 1'b0; guard = 0; prev_out = '0; prev_rnd = '0;
    while (obs_n < 11 && guard < 400) begin
      guard++;
      if (rk_valid !== 1'b1) begin bad_seq++; break; end
      if (key_ready !== 1'b0) bad_ready++;
      if (stalled && (rk_out !== prev_out || rk_round !== prev_rnd)) bad_stall++;
      rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke_kv) begin
        key_valid = 1'($urandom_range(0, 1));
        key_in = {$urandom, $urandom, $urandom, $urandom};
      end
      if (rk_ready) begin
        obs[obs_n] = rk_out;
        if (rk_out !== exp_rk[10-obs_n] || rk_round !== 4'(10 - obs_n)) bad_seq++;
        obs_n++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1; prev_out = rk_out; prev_rnd = rk_round;
      end
      @(posedge clk);
      @(negedge clk);
    end
    rk_ready = 1'b0; key_valid = 1'b0;
    if (obs_n != 11 || rk_valid !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1) bad_seq++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests_run++; if (key_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_key_ready: got %b want 1", key_ready); end
    tests_run++; if (rk_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rk_valid: got %b want 0", rk_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (rk_out !== 128'h0) begin tests_failed++; $display("FAIL reset_rk_out: got %h want 0", rk_out); end
    tests_run++; if (rk_round !== 4'd0) begin tests_failed++; $display("FAIL reset_rk_round: got %0d want 0", rk_round); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++; if (key_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL reset_release: key_ready=%b busy=%b want 1/0", key_ready, busy); end
  endtask

  task automatic test_fips_vector();
    run_seq(FIPS_KEY, 1'b0, 1'b0);
    tests_run++; if (lat !== 11) begin tests_failed++; $display("FAIL fips_latency: got %0d edges want 11", lat); end
    tests_run++; if (obs_n !== 11) begin tests_failed++; $display("FAIL fips_count: got %0d keys want 11", obs_n); end
    tests_run++; if (obs[0] !== FIPS_R10) begin tests_failed++; $display("FAIL fips_round10: got %h want %h", obs[0], FIPS_R10); end
    tests_run++; if (obs[1] !== FIPS_R9) begin tests_failed++; $display("FAIL fips_round9: got %h want %h", obs[1], FIPS_R9); end
    tests_run++; if (obs[9] !== FIPS_R1) begin tests_failed++; $display("FAIL fips_round1: got %h want %h", obs[9], FIPS_R1); end
    tests_run++; if (obs[10] !== FIPS_KEY) begin tests_failed++; $display("FAIL fips_round0: got %h want %h", obs[10], FIPS_KEY); end
    tests_run++; if (bad_seq !== 0) begin tests_failed++; $display("FAIL fips_sequence: got %0d errors want 0", bad_seq); end
    tests_run++; if (bad_ready !== 0) begin tests_failed++; $display("FAIL fips_key_ready: got %0d errors want 0", bad_ready); end
  endtask

  task automatic test_random_stall();
    run_seq(FIPS_KEY, 1'b1, 1'b0);
    tests_run++; if (obs_n !== 11) begin tests_failed++; $display("FAIL stall_count: got %0d keys want 11", obs_n); end
    tests_run++; if (bad_seq !== 0) begin tests_failed++; $display("FAIL stall_sequence: got %0d errors want 0", bad_seq); end
    tests_run++; if (bad_stall !== 0) begin tests_failed++; $display("FAIL stall_hold: got %0d unstable cycles want 0", bad_stall); end
  endtask

  task automatic test_key_valid_ignored();
    run_seq(FIPS_KEY, 1'b1, 1'b1);
    tests_run++; if (lat !== 11) begin tests_failed++; $display("FAIL kv_ignored_latency: got %0d want 11", lat); end
    tests_run++; if (bad_seq !== 0) begin tests_failed++; $display("FAIL kv_ignored_sequence: got %0d errors want 0", bad_seq); end
    tests_run++; if (bad_ready !== 0) begin tests_failed++; $display("FAIL kv_ignored_key_ready: got %0d errors want 0", bad_ready); end
    tests_run++; if (bad_stall !== 0) begin tests_failed++; $display("FAIL kv_ignored_hold: got %0d errors want 0", bad_stall); end
  endtask

  task automatic test_flush();
    int  g;
    bit  seen;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    key_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    key_valid = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    tests_run++; if (busy !== 1'b1 || rk_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_pre_expand: busy=%b rk_valid=%b want 1/0", busy, rk_valid); end
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    tests_run++; if (busy !== 1'b0 || rk_valid !== 1'b0 || key_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_expand: busy=%b rk_valid=%b key_ready=%b want 0/0/1", busy, rk_valid, key_ready); end
    seen = 1'b0;
    repeat (12) begin @(posedge clk); @(negedge clk); if (rk_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1; end
    tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL flush_expand_stays_idle: got activity=%b want 0", seen); end

    key_in = {$urandom, $urandom, $urandom, $urandom};
    key_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    key_valid = 1'b0;
    g = 0;
    while (rk_round !== 4'd4 && g < 60) begin
      rk_ready = rk_valid;
      @(posedge clk); @(negedge clk);
      g++;
    end
    tests_run++; if (rk_valid !== 1'b1 || rk_round !== 4'd4) begin tests_failed++; $display("FAIL flush_reach_round4: rk_valid=%b rk_round=%0d want 1/4", rk_valid, rk_round); end
    rk_ready = 1'b1; flush = 1'b1;
    @(posedge clk); @(negedge clk);
    rk_ready = 1'b0; flush = 1'b0;
    tests_run++; if (rk_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL flush_serve: rk_valid=%b busy=%b want 0/0", rk_valid, busy); end
    tests_run++; if (rk_round !== 4'd0 || rk_out !== 128'h0) begin tests_failed++; $display("FAIL flush_serve_outputs: rk_round=%0d rk_out=%h want 0/0", rk_round, rk_out); end

    key_valid = 1'b1; flush = 1'b1;
    @(posedge clk); @(negedge clk);
    key_valid = 1'b0; flush = 1'b0;
    tests_run++; if (busy !== 1'b0 || key_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_beats_load: busy=%b key_ready=%b want 0/1", busy, key_ready); end

    run_seq({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
    tests_run++; if (bad_seq !== 0 || obs_n !== 11) begin tests_failed++; $display("FAIL flush_recovery: errors=%0d keys=%0d want 0/11", bad_seq, obs_n); end
  endtask

  task automatic test_async_reset();
    int g;
    bit seen;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    key_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    key_valid = 1'b0;
    g = 0;
    while (rk_valid !== 1'b1 && g < 40) begin @(posedge clk); @(negedge clk); g++; end
    repeat (3) begin rk_ready = 1'b1; @(posedge clk); @(negedge clk); end
    rk_ready = 1'b0;
    tests_run++; if (rk_valid !== 1'b1 || rk_round !== 4'd7) begin tests_failed++; $display("FAIL areset_pre: rk_valid=%b rk_round=%0d want 1/7", rk_valid, rk_round); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (rk_valid !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1) begin tests_failed++; $display("FAIL areset_async_ctrl: rk_valid=%b busy=%b key_ready=%b want 0/0/1", rk_valid, busy, key_ready); end
    tests_run++; if (rk_out !== 128'h0 || rk_round !== 4'd0) begin tests_failed++; $display("FAIL areset_async_data: rk_out=%h rk_round=%0d want 0/0", rk_out, rk_round); end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    tests_run++; if (key_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL areset_release: key_ready=%b busy=%b want 1/0", key_ready, busy); end
    rk_ready = 1'b1; seen = 1'b0;
    repeat (15) begin @(posedge clk); @(negedge clk); if (rk_valid !== 1'b0) seen = 1'b1; end
    rk_ready = 1'b0;
    tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL areset_no_residual: got rk_valid activity=%b want 0", seen); end
  endtask

  task automatic test_back_to_back();
    run_seq(128'h0, 1'b0, 1'b0);
    tests_run++; if (obs[0] !== ZERO_R10) begin tests_failed++; $display("FAIL zero_round10: got %h want %h", obs[0], ZERO_R10); end
    tests_run++; if (bad_seq !== 0) begin tests_failed++; $display("FAIL zero_sequence: got %0d errors want 0", bad_seq); end
    run_seq({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
    tests_run++; if (lat !== 11) begin tests_failed++; $display("FAIL b2b_latency: got %0d want 11", lat); end
    tests_run++; if (bad_seq !== 0 || bad_stall !== 0) begin tests_failed++; $display("FAIL b2b_sequence: errors=%0d stalls=%0d want 0/0", bad_seq, bad_stall); end
  endtask

  task automatic test_random_keys();
    for (int k = 0; k < 4; k++) begin
      run_seq({$urandom, $urandom, $urandom, $urandom}, 1'b1, k[0]);
      tests_run++; if (bad_seq !== 0 || bad_stall !== 0 || bad_ready !== 0) begin tests_failed++; $display("FAIL random_key_%0d: errors=%0d stalls=%0d ready_errs=%0d want 0/0/0", k, bad_seq, bad_stall, bad_ready); end
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst_n = 1'b0; key_in = '0; key_valid = 1'b0; flush = 1'b0; rk_ready = 1'b0;
    build_sbox_model();
    test_reset();
    test_fips_vector();
    test_random_stall();
    test_key_valid_ignored();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_random_keys();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
